// File: rtl/apb_master.sv
// APB requester for a two-slave peripheral bus: valid/ready request port in,
// IDLE -> SETUP -> ACCESS sequencing out, with a bounded PREADY wait.
module apb_master #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int SEL_BIT = 7,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL1,
  output logic              PSEL2,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA1,
  input  logic [DATA_W-1:0] PRDATA2,
  input  logic              PREADY
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          accept;

  assign req_ready = (state == IDLE) || ((state == ACCESS) && PREADY);
  assign accept    = req_valid && req_ready;

  // PSELx are decoded from req_addr at the accept edge so they are already
  // registered-high during the SETUP cycle.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      cnt       <= '0;
      PSEL1     <= 1'b0;
      PSEL2     <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            PADDR  <= req_addr;
            PWDATA <= req_wdata;
            PWRITE <= req_write;
            PSEL1  <= !req_addr[SEL_BIT];
            PSEL2  <= req_addr[SEL_BIT];
            state  <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          cnt     <= CW'(1);
          state   <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            rsp_valid <= 1'b1;
            if (!PWRITE) rsp_rdata <= PSEL2 ? PRDATA2 : PRDATA1;
            PENABLE <= 1'b0;
            if (accept) begin
              PADDR  <= req_addr;
              PWDATA <= req_wdata;
              PWRITE <= req_write;
              PSEL1  <= !req_addr[SEL_BIT];
              PSEL2  <= req_addr[SEL_BIT];
              state  <= SETUP;
            end else begin
              PSEL1 <= 1'b0;
              PSEL2 <= 1'b0;
              state <= IDLE;
            end
          end else if (cnt == CNT_MAX) begin
            PSEL1     <= 1'b0;
            PSEL2     <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state     <= IDLE;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          PSEL1   <= 1'b0;
          PSEL2   <= 1'b0;
          PENABLE <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master with a two-slave memory model whose wait
// states and stuck-low PREADY are controlled by the stimulus tasks.
module tb_apb_master;

  logic       PCLK, PRESETn;
  logic       req_valid, req_ready, req_write;
  logic [7:0] req_addr, req_wdata;
  logic       rsp_valid, rsp_err;
  logic [7:0] rsp_rdata;
  logic       PSEL1, PSEL2, PENABLE, PWRITE, PREADY;
  logic [7:0] PADDR, PWDATA, PRDATA1, PRDATA2;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] mem1 [256];
  logic [7:0] mem2 [256];
  int   wcnt = 0;
  int   wait_cfg = 0;
  logic stuck = 1'b0;

  // observations of the last transfer
  int         o_setup, o_access, o_lat;
  logic       o_sel1, o_sel2, o_got, o_stable, o_err;
  logic [7:0] o_rdata;

  apb_master #(.ADDR_W(8), .DATA_W(8), .SEL_BIT(7), .TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA1(PRDATA1), .PRDATA2(PRDATA2), .PREADY(PREADY)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  assign PREADY  = (PSEL1 | PSEL2) && PENABLE && !stuck && (wcnt >= wait_cfg);
  assign PRDATA1 = PSEL1 ? mem1[PADDR] : 8'hFF;
  assign PRDATA2 = PSEL2 ? mem2[PADDR] : 8'hEE;

  always @(posedge PCLK) begin
    wcnt <= ((PSEL1 | PSEL2) && PENABLE && !PREADY) ? wcnt + 1 : 0;
    if (PENABLE && PREADY && PWRITE) begin
      if (PSEL1) mem1[PADDR] <= PWDATA;
      else if (PSEL2) mem2[PADDR] <= PWDATA;
    end
  end

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic xfer(input logic w, input logic [7:0] a, input logic [7:0] d);
    o_setup = 0; o_access = 0; o_lat = 0;
    o_sel1 = 0; o_sel2 = 0; o_got = 0; o_stable = 1; o_err = 0; o_rdata = 8'h00;
    req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid) begin
        o_got = 1; o_rdata = rsp_rdata; o_err = rsp_err;
        break;
      end
      if (PSEL1) o_sel1 = 1;
      if (PSEL2) o_sel2 = 1;
      if (PSEL1 | PSEL2) begin
        if (PENABLE) o_access++; else o_setup++;
        if (PADDR !== a || PWRITE !== w || (w && PWDATA !== d)) o_stable = 0;
      end
      tick();
      o_lat++;
    end
  endtask

  task automatic test_reset();
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
    PRESETn = 0;
    #12;
    n_vec++; if (PSEL1 !== 1'b0 || PSEL2 !== 1'b0) begin n_err++; $display("FAIL reset_psel: got %b%b expected 00", PSEL1, PSEL2); end
    n_vec++; if (PENABLE !== 1'b0 || PWRITE !== 1'b0) begin n_err++; $display("FAIL reset_en_wr: got %b%b expected 00", PENABLE, PWRITE); end
    n_vec++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin n_err++; $display("FAIL reset_rsp: got %b%b expected 00", rsp_valid, rsp_err); end
    n_vec++; if (PADDR !== 8'h00 || PWDATA !== 8'h00) begin n_err++; $display("FAIL reset_bus: got %h/%h expected 00/00", PADDR, PWDATA); end
    n_vec++; if (rsp_rdata !== 8'h00) begin n_err++; $display("FAIL reset_rdata: got %h expected 00", rsp_rdata); end
    @(negedge PCLK);
    PRESETn = 1;
    tick();
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_slave1();
    xfer(1'b1, 8'h05, 8'hA5);
    n_vec++; if (o_got !== 1'b1 || o_err !== 1'b0) begin n_err++; $display("FAIL s1_wr_rsp: got valid=%b err=%b expected 1/0", o_got, o_err); end
    n_vec++; if (o_setup != 1 || o_access != 1) begin n_err++; $display("FAIL s1_wr_phases: got setup=%0d access=%0d expected 1/1", o_setup, o_access); end
    n_vec++; if (o_lat != 2) begin n_err++; $display("FAIL s1_wr_latency: got %0d expected 2", o_lat); end
    n_vec++; if (o_sel1 !== 1'b1 || o_sel2 !== 1'b0 || o_stable !== 1'b1) begin n_err++; $display("FAIL s1_wr_sel: got sel1=%b sel2=%b stable=%b expected 1/0/1", o_sel1, o_sel2, o_stable); end
    tick();
    n_vec++; if (rsp_valid !== 1'b0 || PSEL1 !== 1'b0) begin n_err++; $display("FAIL s1_wr_idle: got rsp_valid=%b psel1=%b expected 0/0", rsp_valid, PSEL1); end
    xfer(1'b0, 8'h05, 8'h00);
    n_vec++; if (o_got !== 1'b1 || o_err !== 1'b0 || o_rdata !== 8'hA5) begin n_err++; $display("FAIL s1_rd: got valid=%b err=%b data=%h expected 1/0/a5", o_got, o_err, o_rdata); end
    n_vec++; if (o_sel1 !== 1'b1 || o_sel2 !== 1'b0 || o_stable !== 1'b1 || o_lat != 2) begin n_err++; $display("FAIL s1_rd_bus: got sel1=%b sel2=%b stable=%b lat=%0d expected 1/0/1/2", o_sel1, o_sel2, o_stable, o_lat); end
    tick();
  endtask

  task automatic test_slave2();
    xfer(1'b1, 8'h83, 8'h3C);
    n_vec++; if (o_got !== 1'b1 || o_rdata !== 8'hA5) begin n_err++; $display("FAIL s2_wr_keep_rdata: got valid=%b data=%h expected 1/a5", o_got, o_rdata); end
    n_vec++; if (o_sel1 !== 1'b0 || o_sel2 !== 1'b1 || o_stable !== 1'b1) begin n_err++; $display("FAIL s2_wr_sel: got sel1=%b sel2=%b stable=%b expected 0/1/1", o_sel1, o_sel2, o_stable); end
    tick();
    xfer(1'b0, 8'h83, 8'h00);
    n_vec++; if (o_got !== 1'b1 || o_err !== 1'b0 || o_rdata !== 8'h3C) begin n_err++; $display("FAIL s2_rd: got valid=%b err=%b data=%h expected 1/0/3c", o_got, o_err, o_rdata); end
    n_vec++; if (o_sel1 !== 1'b0 || o_sel2 !== 1'b1) begin n_err++; $display("FAIL s2_rd_sel: got sel1=%b sel2=%b expected 0/1", o_sel1, o_sel2); end
    tick();
  endtask

  task automatic test_wait_states();
    xfer(1'b1, 8'h10, 8'h66);
    tick();
    wait_cfg = 3;
    xfer(1'b0, 8'h10, 8'h00);
    wait_cfg = 0;
    n_vec++; if (o_access != 4 || o_setup != 1) begin n_err++; $display("FAIL wait_phases: got setup=%0d access=%0d expected 1/4", o_setup, o_access); end
    n_vec++; if (o_lat != 5) begin n_err++; $display("FAIL wait_latency: got %0d expected 5", o_lat); end
    n_vec++; if (o_got !== 1'b1 || o_rdata !== 8'h66 || o_stable !== 1'b1) begin n_err++; $display("FAIL wait_rd: got valid=%b data=%h stable=%b expected 1/66/1", o_got, o_rdata, o_stable); end
    tick();
  endtask

  task automatic test_back_to_back();
    req_write = 1; req_addr = 8'h01; req_wdata = 8'h11; req_valid = 1;
    tick();
    req_addr = 8'h82; req_wdata = 8'h22;
    n_vec++; if (PSEL1 !== 1'b1 || PENABLE !== 1'b0 || req_ready !== 1'b0) begin n_err++; $display("FAIL b2b_setup1: got sel1=%b en=%b ready=%b expected 1/0/0", PSEL1, PENABLE, req_ready); end
    tick();
    n_vec++; if (PSEL1 !== 1'b1 || PENABLE !== 1'b1 || req_ready !== 1'b1 || PADDR !== 8'h01) begin n_err++; $display("FAIL b2b_access1: got sel1=%b en=%b ready=%b addr=%h expected 1/1/1/01", PSEL1, PENABLE, req_ready, PADDR); end
    tick();
    req_valid = 0;
    n_vec++; if (PSEL2 !== 1'b1 || PSEL1 !== 1'b0 || PENABLE !== 1'b0 || PADDR !== 8'h82 || PWDATA !== 8'h22) begin n_err++; $display("FAIL b2b_setup2: got sel=%b%b en=%b addr=%h wd=%h expected 01/0/82/22", PSEL1, PSEL2, PENABLE, PADDR, PWDATA); end
    n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL b2b_rsp1: got %b expected 1", rsp_valid); end
    tick();
    n_vec++; if (rsp_valid !== 1'b0 || PSEL2 !== 1'b1 || PENABLE !== 1'b1) begin n_err++; $display("FAIL b2b_access2: got rsp=%b sel2=%b en=%b expected 0/1/1", rsp_valid, PSEL2, PENABLE); end
    tick();
    n_vec++; if (rsp_valid !== 1'b1 || PSEL2 !== 1'b0 || PENABLE !== 1'b0) begin n_err++; $display("FAIL b2b_rsp2: got rsp=%b sel2=%b en=%b expected 1/0/0", rsp_valid, PSEL2, PENABLE); end
    n_vec++; if (mem1[8'h01] !== 8'h11 || mem2[8'h82] !== 8'h22) begin n_err++; $display("FAIL b2b_mem: got %h/%h expected 11/22", mem1[8'h01], mem2[8'h82]); end
    tick();
  endtask

  task automatic test_timeout();
    stuck = 1;
    xfer(1'b0, 8'h20, 8'h00);
    stuck = 0;
    n_vec++; if (o_access != 16 || o_lat != 17) begin n_err++; $display("FAIL tmo_cycles: got access=%0d lat=%0d expected 16/17", o_access, o_lat); end
    n_vec++; if (o_got !== 1'b1 || o_err !== 1'b1 || o_rdata !== 8'h00) begin n_err++; $display("FAIL tmo_rsp: got valid=%b err=%b data=%h expected 1/1/00", o_got, o_err, o_rdata); end
    n_vec++; if (PSEL1 !== 1'b0 || PENABLE !== 1'b0) begin n_err++; $display("FAIL tmo_bus: got sel1=%b en=%b expected 0/0", PSEL1, PENABLE); end
    tick();
    xfer(1'b0, 8'h05, 8'h00);
    n_vec++; if (o_got !== 1'b1 || o_err !== 1'b0 || o_rdata !== 8'hA5 || o_lat != 2) begin n_err++; $display("FAIL tmo_recover: got valid=%b err=%b data=%h lat=%0d expected 1/0/a5/2", o_got, o_err, o_rdata, o_lat); end
    tick();
  endtask

  task automatic test_async_reset();
    logic seen;
    stuck = 1;
    req_write = 0; req_addr = 8'h10; req_valid = 1;
    tick();
    req_valid = 0;
    tick();
    tick();
    n_vec++; if (PENABLE !== 1'b1 || PSEL1 !== 1'b1) begin n_err++; $display("FAIL arst_pre: got sel1=%b en=%b expected 1/1", PSEL1, PENABLE); end
    #2 PRESETn = 0;
    #1;
    n_vec++; if (PSEL1 !== 1'b0 || PSEL2 !== 1'b0 || PENABLE !== 1'b0 || PADDR !== 8'h00) begin n_err++; $display("FAIL arst_async: got sel=%b%b en=%b addr=%h expected 00/0/00", PSEL1, PSEL2, PENABLE, PADDR); end
    tick();
    #2 PRESETn = 1;
    stuck = 0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rsp_valid) seen = 1;
    end
    n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL arst_no_rsp: got %b expected 0", seen); end
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL arst_ready: got %b expected 1", req_ready); end
  endtask

  initial begin
    test_reset();
    test_slave1();
    test_slave2();
    test_wait_states();
    test_back_to_back();
    test_timeout();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
